// File: rtl/attn_pkg.sv
// Shared definitions for the attention-engine blocks around the systolic array.
package attn_pkg;

   localparam int M_DIM_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of pend at or after ptr, wrapping.
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int SEL_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] pend,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_REQ-1:0] win,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

   always_comb begin
      logic [SEL_W-1:0] j;
      win = '0;
      idx = '0;
      j   = '0;
      // Scan farthest-first so the request nearest to ptr is the last writer.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = SEL_W'((int'(ptr) + k) % N_REQ);
         if (pend[j]) begin
            idx = j;
         end
      end
      if (|pend) begin
         win[idx] = 1'b1;
      end
   end

   assign any = |pend;

endmodule

// File: rtl/sa_arbiter.sv
// Round-robin owner arbitration of one shared systolic array across N_REQ engines,
// with start issue, done return, duplicate-start drop and a busy watchdog.
module sa_arbiter
   import attn_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int SEL_W = $clog2(N_REQ),
   parameter int TMO_W = 12
) (
   input  logic                            I_CLK,
   input  logic                            I_ASYN_RST,
   input  logic [N_REQ-1:0]                I_REQ_START,
   input  logic [N_REQ-1:0][M_DIM_W-1:0]   I_REQ_M_DIM,
   input  logic                            I_SA_VLD,
   output logic                            O_SA_START,
   output logic [M_DIM_W-1:0]              O_M_DIM,
   output logic [N_REQ-1:0]                O_GRANT,
   output logic [SEL_W-1:0]                O_SEL,
   output logic [N_REQ-1:0]                O_DONE,
   output logic                            O_TMO,
   output logic                            O_DROP,
   output arb_state_t                      O_STATE
);

   // The BUSY cycle that sees this count is the (2**TMO_W-1)-th one.
   localparam logic [TMO_W-1:0] WD_LAST = TMO_W'((2 ** TMO_W) - 2);

   arb_state_t       state;
   logic [N_REQ-1:0] pend;
   logic [SEL_W-1:0] ptr;
   logic [TMO_W-1:0] wdog;

   logic [N_REQ-1:0] win;
   logic [SEL_W-1:0] win_idx;
   logic             any;
   logic             take;
   logic [N_REQ-1:0] dup;
   logic [N_REQ-1:0] pend_clr;
   logic [SEL_W-1:0] ptr_nxt;

   rr_pick #(
      .N_REQ (N_REQ),
      .SEL_W (SEL_W)
   ) u_pick (
      .pend (pend),
      .ptr  (ptr),
      .win  (win),
      .idx  (win_idx),
      .any  (any)
   );

   // DONE also arbitrates so a waiting requester is granted right after the done pulse.
   always_comb begin
      take     = ((state == IDLE) || (state == DONE)) && any;
      dup      = I_REQ_START & (pend | O_GRANT);
      pend_clr = take ? win : '0;
      ptr_nxt  = SEL_W'((int'(win_idx) + 1) % N_REQ);
   end

   assign O_STATE = state;

   always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
      if (I_ASYN_RST) begin
         state      <= IDLE;
         pend       <= '0;
         ptr        <= '0;
         wdog       <= '0;
         O_SA_START <= 1'b0;
         O_M_DIM    <= '0;
         O_GRANT    <= '0;
         O_SEL      <= '0;
         O_DONE     <= '0;
         O_TMO      <= 1'b0;
         O_DROP     <= 1'b0;
      end else begin
         pend       <= (pend & ~pend_clr) | (I_REQ_START & ~dup);
         O_DROP     <= |dup;
         O_SA_START <= 1'b0;
         O_DONE     <= '0;
         case (state)
            IDLE, DONE: begin
               if (take) begin
                  O_GRANT <= win;
                  O_SEL   <= win_idx;
                  O_M_DIM <= I_REQ_M_DIM[win_idx];
                  ptr     <= ptr_nxt;
                  state   <= ISSUE;
               end else if (state == DONE) begin
                  O_GRANT <= '0;
                  state   <= IDLE;
               end
            end
            ISSUE: begin
               O_SA_START <= 1'b1;
               wdog       <= '0;
               state      <= BUSY;
            end
            BUSY: begin
               if (I_SA_VLD) begin
                  O_DONE <= O_GRANT;
                  state  <= DONE;
               end else if (wdog == WD_LAST) begin
                  O_TMO  <= 1'b1;
                  O_DONE <= O_GRANT;
                  state  <= DONE;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sa_arbiter.sv
// Scenario bench for sa_arbiter: a main instance plus a short-watchdog instance.
module tb_sa_arbiter;
   import attn_pkg::*;

   localparam int N     = 4;
   localparam int SEL_W = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N-1:0]              req_start;
   logic [N-1:0][M_DIM_W-1:0] req_m_dim;
   logic                      sa_vld;
   logic                      sa_start;
   logic [M_DIM_W-1:0]        m_dim;
   logic [N-1:0]              grant;
   logic [SEL_W-1:0]          sel;
   logic [N-1:0]              done;
   logic                      tmo;
   logic                      drop;
   arb_state_t                state;

   logic [N-1:0]              w_start;
   logic                      w_vld;
   logic                      w_sa_start;
   logic [M_DIM_W-1:0]        w_m_dim;
   logic [N-1:0]              w_grant;
   logic [SEL_W-1:0]          w_sel;
   logic [N-1:0]              w_done;
   logic                      w_tmo;
   logic                      w_drop;
   arb_state_t                w_state;

   sa_arbiter #(.N_REQ(N), .SEL_W(SEL_W), .TMO_W(12)) u_dut (
      .I_CLK (clk), .I_ASYN_RST (rst), .I_REQ_START (req_start), .I_REQ_M_DIM (req_m_dim),
      .I_SA_VLD (sa_vld), .O_SA_START (sa_start), .O_M_DIM (m_dim), .O_GRANT (grant),
      .O_SEL (sel), .O_DONE (done), .O_TMO (tmo), .O_DROP (drop), .O_STATE (state)
   );

   sa_arbiter #(.N_REQ(N), .SEL_W(SEL_W), .TMO_W(4)) u_wdt (
      .I_CLK (clk), .I_ASYN_RST (rst), .I_REQ_START (w_start), .I_REQ_M_DIM (req_m_dim),
      .I_SA_VLD (w_vld), .O_SA_START (w_sa_start), .O_M_DIM (w_m_dim), .O_GRANT (w_grant),
      .O_SEL (w_sel), .O_DONE (w_done), .O_TMO (w_tmo), .O_DROP (w_drop), .O_STATE (w_state)
   );

   int total = 0;
   int bad   = 0;
   int starts = 0;
   logic [N-1:0] exp_q[$];
   logic [N-1:0] sb_exp;

   // Scoreboard: every done pulse of the main instance must match the next queued owner.
   always @(negedge clk) begin
      if (!rst) begin
         if (sa_start) starts++;
         if (done != '0) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_done: got done=%b but none expected", done);
            end else begin
               sb_exp = exp_q.pop_front();
               if (done !== sb_exp) begin
                  bad++;
                  $display("FAIL sb_done: got done=%b want %b", done, sb_exp);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "global timeout");
   end

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      req_start = '0;
      w_start = '0;
      sa_vld = 1'b0;
      w_vld = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      starts = 0;
   endtask

   // Serve one grant: wait for the array start, check owner, answer after lat cycles.
   task automatic serve(input int exp_idx, input int lat,
                        input logic [N-1:0] mid_start, input logic [N-1:0] post_start);
      int n;
      logic [N-1:0] oh;
      oh = '0;
      oh[exp_idx] = 1'b1;
      n = 0;
      while (sa_start !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (sa_start !== 1'b1) begin
         bad++;
         $display("FAIL serve_timeout: no start for requester %0d after %0d cycles", exp_idx, n);
         return;
      end
      total++;
      if (grant !== oh) begin
         bad++;
         $display("FAIL serve_grant: got %b want %b", grant, oh);
      end
      total++;
      if (sel !== SEL_W'(exp_idx)) begin
         bad++;
         $display("FAIL serve_sel: got %0d want %0d", sel, exp_idx);
      end
      req_start = mid_start;
      repeat (lat) begin
         @(negedge clk);
         req_start = '0;
      end
      sa_vld = 1'b1;
      @(negedge clk);
      sa_vld = 1'b0;
      total++;
      if (done !== oh) begin
         bad++;
         $display("FAIL serve_done: got %b want %b", done, oh);
      end
      @(negedge clk);
      req_start = post_start;
      @(negedge clk);
      req_start = '0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_start = '0;
      w_start = '0;
      sa_vld = 1'b0;
      w_vld = 1'b0;
      for (int i = 0; i < N; i++) req_m_dim[i] = M_DIM_W'($urandom_range(1, 255));
      @(negedge clk);
      total++; if (sa_start !== 1'b0) begin bad++; $display("FAIL rst_sa_start: got %b want 0", sa_start); end
      total++; if (m_dim !== 8'd0) begin bad++; $display("FAIL rst_m_dim: got %0d want 0", m_dim); end
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL rst_grant: got %b want 0000", grant); end
      total++; if (sel !== 2'd0) begin bad++; $display("FAIL rst_sel: got %0d want 0", sel); end
      total++; if (done !== 4'b0) begin bad++; $display("FAIL rst_done: got %b want 0000", done); end
      total++; if (tmo !== 1'b0) begin bad++; $display("FAIL rst_tmo: got %b want 0", tmo); end
      total++; if (drop !== 1'b0) begin bad++; $display("FAIL rst_drop: got %b want 0", drop); end
      total++; if (state !== IDLE) begin bad++; $display("FAIL rst_state: got %0d want IDLE", state); end
      rst = 1'b0;
   endtask

   task automatic test_single;
      do_reset();
      req_m_dim[1] = 8'd16;
      exp_q.push_back(4'b0010);
      req_start = 4'b0010;
      @(negedge clk);
      req_start = '0;
      sa_vld = 1'b1;
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL single_early_grant: got %b want 0000", grant); end
      @(negedge clk);
      sa_vld = 1'b1;
      total++; if (grant !== 4'b0010) begin bad++; $display("FAIL single_grant: got %b want 0010", grant); end
      total++; if (sel !== 2'd1) begin bad++; $display("FAIL single_sel: got %0d want 1", sel); end
      total++; if (m_dim !== 8'd16) begin bad++; $display("FAIL single_m_dim: got %0d want 16", m_dim); end
      total++; if (sa_start !== 1'b0) begin bad++; $display("FAIL single_start_early: got %b want 0", sa_start); end
      @(negedge clk);
      sa_vld = 1'b0;
      total++; if (sa_start !== 1'b1) begin bad++; $display("FAIL single_start: got %b want 1", sa_start); end
      total++; if (done !== 4'b0) begin bad++; $display("FAIL single_vld_ignored: got %b want 0000", done); end
      @(negedge clk);
      total++; if (sa_start !== 1'b0) begin bad++; $display("FAIL single_start_width: got %b want 0", sa_start); end
      repeat (36) @(negedge clk);
      sa_vld = 1'b1;
      @(negedge clk);
      sa_vld = 1'b0;
      total++; if (done !== 4'b0010) begin bad++; $display("FAIL single_done: got %b want 0010", done); end
      total++; if (grant !== 4'b0010) begin bad++; $display("FAIL single_grant_hold: got %b want 0010", grant); end
      @(negedge clk);
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL single_release: got %b want 0000", grant); end
      total++; if (done !== 4'b0) begin bad++; $display("FAIL single_done_width: got %b want 0000", done); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_sb_left: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_all_four;
      do_reset();
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000);
      exp_q.push_back(4'b0001);
      req_start = 4'b1111;
      @(negedge clk);
      req_start = '0;
      serve(0, $urandom_range(1, 8), 4'b0000, 4'b0000);
      serve(1, $urandom_range(1, 8), 4'b0000, 4'b0000);
      serve(2, $urandom_range(1, 8), 4'b0000, 4'b0000);
      serve(3, $urandom_range(1, 8), 4'b0001, 4'b0000);
      serve(0, $urandom_range(1, 8), 4'b0000, 4'b0000);
      repeat (5) @(negedge clk);
      total++; if (starts != 5) begin bad++; $display("FAIL all4_starts: got %0d want 5", starts); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL all4_sb_left: got %0d want 0", exp_q.size()); end
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL all4_idle: got %b want 0000", grant); end
   endtask

   task automatic test_back_to_back;
      do_reset();
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b1000);
      req_start = 4'b1010;
      @(negedge clk);
      req_start = '0;
      repeat (2) @(negedge clk);
      total++; if (sa_start !== 1'b1) begin bad++; $display("FAIL b2b_first_start: got %b want 1", sa_start); end
      repeat (3) @(negedge clk);
      sa_vld = 1'b1;
      @(negedge clk);
      sa_vld = 1'b0;
      total++; if (done !== 4'b0010) begin bad++; $display("FAIL b2b_done1: got %b want 0010", done); end
      @(negedge clk);
      total++; if (grant !== 4'b1000) begin bad++; $display("FAIL b2b_grant2: got %b want 1000", grant); end
      total++; if (sel !== 2'd3) begin bad++; $display("FAIL b2b_sel2: got %0d want 3", sel); end
      total++; if (m_dim !== req_m_dim[3]) begin bad++; $display("FAIL b2b_m_dim2: got %0d want %0d", m_dim, req_m_dim[3]); end
      @(negedge clk);
      total++; if (sa_start !== 1'b1) begin bad++; $display("FAIL b2b_start2: got %b want 1", sa_start); end
      sa_vld = 1'b1;
      @(negedge clk);
      sa_vld = 1'b0;
      @(negedge clk);
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL b2b_release: got %b want 0000", grant); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_sb_left: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_fairness;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(4'b0001);
         exp_q.push_back(4'b0100);
      end
      req_start = 4'b0101;
      @(negedge clk);
      req_start = '0;
      serve(0, $urandom_range(1, 6), 4'b0000, 4'b0001);
      serve(2, $urandom_range(1, 6), 4'b0000, 4'b0100);
      serve(0, $urandom_range(1, 6), 4'b0000, 4'b0001);
      serve(2, $urandom_range(1, 6), 4'b0000, 4'b0100);
      serve(0, $urandom_range(1, 6), 4'b0000, 4'b0000);
      serve(2, $urandom_range(1, 6), 4'b0000, 4'b0000);
      repeat (5) @(negedge clk);
      total++; if (starts != 6) begin bad++; $display("FAIL fair_starts: got %0d want 6", starts); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL fair_sb_left: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_duplicate;
      do_reset();
      exp_q.push_back(4'b0100);
      req_start = 4'b0100;
      @(negedge clk);
      total++; if (drop !== 1'b0) begin bad++; $display("FAIL dup_first_drop: got %b want 0", drop); end
      req_start = 4'b0100;
      @(negedge clk);
      req_start = '0;
      total++; if (drop !== 1'b1) begin bad++; $display("FAIL dup_drop: got %b want 1", drop); end
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL dup_grant: got %b want 0100", grant); end
      @(negedge clk);
      total++; if (drop !== 1'b0) begin bad++; $display("FAIL dup_drop_width: got %b want 0", drop); end
      serve(2, $urandom_range(2, 6), 4'b0100, 4'b0000);
      repeat (10) @(negedge clk);
      total++; if (starts != 1) begin bad++; $display("FAIL dup_starts: got %0d want 1", starts); end
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL dup_idle: got %b want 0000", grant); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL dup_sb_left: got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_watchdog;
      do_reset();
      w_start = 4'b0101;
      @(negedge clk);
      w_start = '0;
      @(negedge clk);
      total++; if (w_grant !== 4'b0001) begin bad++; $display("FAIL wd_grant: got %b want 0001", w_grant); end
      @(negedge clk);
      total++; if (w_sa_start !== 1'b1) begin bad++; $display("FAIL wd_start: got %b want 1", w_sa_start); end
      repeat (14) @(negedge clk);
      total++; if (w_done !== 4'b0) begin bad++; $display("FAIL wd_early_done: got %b want 0000", w_done); end
      total++; if (w_tmo !== 1'b0) begin bad++; $display("FAIL wd_early_tmo: got %b want 0", w_tmo); end
      @(negedge clk);
      total++; if (w_done !== 4'b0001) begin bad++; $display("FAIL wd_done: got %b want 0001", w_done); end
      total++; if (w_tmo !== 1'b1) begin bad++; $display("FAIL wd_tmo: got %b want 1", w_tmo); end
      @(negedge clk);
      total++; if (w_grant !== 4'b0100) begin bad++; $display("FAIL wd_next_grant: got %b want 0100", w_grant); end
      @(negedge clk);
      total++; if (w_sa_start !== 1'b1) begin bad++; $display("FAIL wd_next_start: got %b want 1", w_sa_start); end
      w_vld = 1'b1;
      @(negedge clk);
      w_vld = 1'b0;
      total++; if (w_done !== 4'b0100) begin bad++; $display("FAIL wd_next_done: got %b want 0100", w_done); end
      total++; if (w_tmo !== 1'b1) begin bad++; $display("FAIL wd_tmo_sticky: got %b want 1", w_tmo); end
   endtask

   // Runs straight after the watchdog scenario so the sticky flag is still set.
   task automatic test_reset_mid_busy;
      req_m_dim[1] = 8'd16;
      req_start = 4'b0010;
      @(negedge clk);
      req_start = '0;
      repeat (2) @(negedge clk);
      total++; if (sa_start !== 1'b1) begin bad++; $display("FAIL rmb_start: got %b want 1", sa_start); end
      repeat (3) @(negedge clk);
      total++; if (state !== BUSY) begin bad++; $display("FAIL rmb_busy: got %0d want BUSY", state); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL rmb_grant: got %b want 0000", grant); end
      total++; if (sel !== 2'd0) begin bad++; $display("FAIL rmb_sel: got %0d want 0", sel); end
      total++; if (m_dim !== 8'd0) begin bad++; $display("FAIL rmb_m_dim: got %0d want 0", m_dim); end
      total++; if (state !== IDLE) begin bad++; $display("FAIL rmb_state: got %0d want IDLE", state); end
      total++; if (w_tmo !== 1'b0) begin bad++; $display("FAIL rmb_tmo: got %b want 0", w_tmo); end
      @(negedge clk);
      rst = 1'b0;
      sa_vld = 1'b1;
      @(negedge clk);
      sa_vld = 1'b0;
      total++; if (done !== 4'b0) begin bad++; $display("FAIL rmb_stray_done: got %b want 0000", done); end
      repeat (3) @(negedge clk);
      total++; if (grant !== 4'b0) begin bad++; $display("FAIL rmb_idle: got %b want 0000", grant); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rmb_sb_left: got %0d want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_back_to_back();
      test_fairness();
      test_duplicate();
      test_watchdog();
      test_reset_mid_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
